async_receiver: RTL and testbench
=================================

# async_receiver

UART receiver for the RS-232 link: the companion to the board's transmitter. It oversamples the asynchronous RxD line, filters glitches, and deframes 8-bit, no-parity, 1-stop-bit characters (LSB first). Each received byte is presented for one clock with a strobe. It sits between the RxD pin and the command/terminal logic, all in the 50 MHz domain.

## Interface
Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- OVERSAMPLING, 8, oversample ticks per bit; power of two, ≥4.

Ports:
- FPGA_CLK1_50  input  1  system clock; only clock in the block.
- reset  input  1  asynchronous, active-high reset.
- RxD  input  1  serial line, idle high, asynchronous to clock.
- RxD_data_ready  output  1  one-cycle strobe: RxD_data holds a new valid byte.
- RxD_data  output  8  last good byte; holds its value until the next good byte.
- RxD_frame_error  output  1  one-cycle strobe: stop bit sampled low.
- RxD_busy  output  1  high while a frame is in progress or the receiver is waiting for the line to return high.
- RxD_idle  output  1  line idle for ≥16 bit times (0 when the macro is off).
- RxD_endofpacket  output  1  one-cycle strobe at idle onset after ≥1 byte (0 when the macro is off).

## Operation
- Tick generator: 16-bit phase accumulator, always enabled. Increment = round(BAUD·OVERSAMPLING·2^16/CLK_FREQ). The carry-out is the one-cycle oversample tick.
- Synchronizer: 2 flops, reset to 1.
- Filter: 2-bit saturating counter updated on tick. It increments on sync=1 and decrements on sync=0. Filtered bit goes to 1 at count 3 and to 0 at count 0, otherwise holds. Filter count and filtered bit reset to 3 and 1.
- Bit counter: log2(OVERSAMPLING) bits, counting ticks.
- State machine:
  - IDLE: on filtered bit = 0, go to START and clear the tick counter.
  - START: after OVERSAMPLING/2 ticks, sample. If 0, go to DATA with bit index 0 and clear the tick counter. If 1, treat as a false start and return to IDLE.
  - DATA: every OVERSAMPLING ticks, shift the filtered bit into the MSB of the shift register, so bits arrive LSB first. After bit index 7, go to STOP.
  - STOP: after OVERSAMPLING ticks, sample. If 1: RxD_data ← shift register, pulse RxD_data_ready, go to IDLE. If 0: pulse RxD_frame_error, leave RxD_data unchanged, go to BREAK.
  - BREAK: wait for filtered bit = 1, then go to IDLE.
- RxD_busy = (state ≠ IDLE).
- Reset mid-frame: all state is cleared at once and any partial byte is discarded. The next falling edge after reset starts a fresh frame.

## Timing
- Reset values: RxD_data_ready 0, RxD_data 0x00, RxD_frame_error 0, RxD_busy 0, RxD_idle 0, RxD_endofpacket 0.
- All outputs are registered.
- Strobes are exactly one FPGA_CLK1_50 cycle wide. They rise on the clock edge after the tick that samples the stop bit.
- Filter latency: 2 sync cycles plus 2–3 ticks. The sample point is the nominal bit centre, delayed by the same amount.
- Data-ready is asserted about 9.5 bit times after the start-bit falling edge (about 4120 clocks at default parameters).
- Back-to-back frames with a single stop bit are received without loss, because IDLE accepts a new start on the tick after STOP.
- A line pulse shorter than 2 ticks (about 108 clocks at defaults) is rejected.
- RxD_data_ready and RxD_frame_error are never high together.

## Configuration
- UART_RX_IDLE_DETECT_EN defined: adds a gap counter.
  - The counter counts ticks while state = IDLE and the filtered line is high, and saturates at 16·OVERSAMPLING. It clears on any start.
  - RxD_idle is high while the counter is saturated.
  - RxD_endofpacket pulses one cycle when the counter first reaches saturation, only if at least one byte was received since the last pulse (tracked by a flag cleared on reset and on the pulse).
- UART_RX_IDLE_DETECT_EN undefined: no gap logic is built, and RxD_idle and RxD_endofpacket are tied to 0.

## Test plan
All scenarios use default parameters, 8.68 µs bits, 8N1.
- Send 0x55 → one RxD_data_ready pulse, RxD_data = 0x55, RxD_frame_error stays 0, RxD_busy drops in the same cycle as the strobe.
- Send 0xA5 then 0x3C back-to-back with one stop bit → two strobes; data 0xA5 then 0x3C, each held until the next strobe.
- Drive a low glitch on RxD for 40 clocks while idle → RxD_busy stays 0, no strobes.
- Send 0xFF with the stop bit low, then hold low for 3 bit times → RxD_frame_error pulses once, RxD_data unchanged, RxD_busy high until the line returns high.
- Assert reset during data bit 3 of 0x12, release, then send 0x81 → all outputs at their reset values during reset, then one strobe with RxD_data = 0x81.
- Send 0x41 then keep the line idle for 20 bit times:
  - macro on → RxD_endofpacket pulses once about 16 bit times after the stop bit, and RxD_idle stays high.
  - macro off → both stay 0.

Source files
------------

// File: rtl/async_receiver_if.sv
// Serial-line and received-byte signals of the RS-232 receiver.
// master drives RxD and observes the results; slave is the receiver itself.
interface async_receiver_if;
  logic       RxD;
  logic       RxD_data_ready;
  logic [7:0] RxD_data;
  logic       RxD_frame_error;
  logic       RxD_busy;
  logic       RxD_idle;
  logic       RxD_endofpacket;

  modport master (
    output RxD,
    input  RxD_data_ready, RxD_data, RxD_frame_error, RxD_busy, RxD_idle, RxD_endofpacket
  );

  modport slave (
    input  RxD,
    output RxD_data_ready, RxD_data, RxD_frame_error, RxD_busy, RxD_idle, RxD_endofpacket
  );
endinterface

// File: rtl/async_receiver.sv
// 8N1 UART receiver: oversampled, glitch-filtered RxD deframed into byte strobes.
// Optional gap detector (RxD_idle / RxD_endofpacket) is built when UART_RX_IDLE_DETECT_EN is defined.
module async_receiver #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int OVERSAMPLING = 8
) (
  input  logic FPGA_CLK1_50,
  input  logic reset,
  async_receiver_if.slave rx
);

  localparam int     CNT_W   = $clog2(OVERSAMPLING);
  localparam longint INC_NUM = longint'(BAUD) * longint'(OVERSAMPLING) * 131072 + longint'(CLK_FREQ);
  localparam longint INC_DEN = 2 * longint'(CLK_FREQ);
  localparam logic [15:0] INC = 16'(INC_NUM / INC_DEN);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLING - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic [15:0]      acc_reg;
  logic             tick_reg;
  logic [1:0]       sync_reg;
  logic [1:0]       filt_cnt_reg;
  logic [1:0]       filt_cnt_next;
  logic             filt_reg;
  state_t           state_reg;
  logic [CNT_W-1:0] tick_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       data_reg;
  logic             ready_reg;
  logic             ferr_reg;
  logic             busy_reg;

  // Carry-out of the phase accumulator is the oversample tick
  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      acc_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      {tick_reg, acc_reg} <= {1'b0, acc_reg} + {1'b0, INC};
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx.RxD};
    end
  end

  always_comb begin
    filt_cnt_next = filt_cnt_reg;
    if (sync_reg[1] && filt_cnt_reg != 2'd3) begin
      filt_cnt_next = filt_cnt_reg + 2'd1;
    end else if (!sync_reg[1] && filt_cnt_reg != 2'd0) begin
      filt_cnt_next = filt_cnt_reg - 2'd1;
    end
  end

  // Filtered bit only flips at the saturation ends, so short pulses never reach it
  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      filt_cnt_reg <= 2'd3;
      filt_reg     <= 1'b1;
    end else if (tick_reg) begin
      filt_cnt_reg <= filt_cnt_next;
      if (filt_cnt_next == 2'd3) begin
        filt_reg <= 1'b1;
      end else if (filt_cnt_next == 2'd0) begin
        filt_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      tick_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      data_reg     <= '0;
      ready_reg    <= 1'b0;
      ferr_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      if (tick_reg) begin
        case (state_reg)
          S_IDLE: begin
            if (!filt_reg) begin
              state_reg    <= S_START;
              tick_cnt_reg <= '0;
              busy_reg     <= 1'b1;
            end
          end
          S_START: begin
            tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
            if (tick_cnt_reg == HALF_LAST) begin
              tick_cnt_reg <= '0;
              if (filt_reg) begin
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
              end else begin
                state_reg   <= S_DATA;
                bit_idx_reg <= '0;
              end
            end
          end
          S_DATA: begin
            tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
            if (tick_cnt_reg == FULL_LAST) begin
              shift_reg   <= {filt_reg, shift_reg[7:1]};
              bit_idx_reg <= bit_idx_reg + 3'd1;
              if (bit_idx_reg == 3'd7) begin
                state_reg <= S_STOP;
              end
            end
          end
          S_STOP: begin
            tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
            if (tick_cnt_reg == FULL_LAST) begin
              if (filt_reg) begin
                data_reg  <= shift_reg;
                ready_reg <= 1'b1;
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
              end else begin
                ferr_reg  <= 1'b1;
                state_reg <= S_BREAK;
              end
            end
          end
          S_BREAK: begin
            if (filt_reg) begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end
          end
          default: begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx.RxD_data_ready  = ready_reg;
  assign rx.RxD_data        = data_reg;
  assign rx.RxD_frame_error = ferr_reg;
  assign rx.RxD_busy        = busy_reg;

`ifdef UART_RX_IDLE_DETECT_EN
  localparam int GAP_SAT = 16 * OVERSAMPLING;
  localparam int GAP_W   = $clog2(GAP_SAT + 1);

  logic [GAP_W-1:0] gap_reg;
  logic             idle_reg;
  logic             eop_reg;
  logic             got_byte_reg;

  // End-of-packet fires once per burst: only when a byte arrived since the last pulse
  always_ff @(posedge FPGA_CLK1_50 or posedge reset) begin
    if (reset) begin
      gap_reg      <= '0;
      idle_reg     <= 1'b0;
      eop_reg      <= 1'b0;
      got_byte_reg <= 1'b0;
    end else begin
      eop_reg <= 1'b0;
      if (tick_reg && state_reg == S_IDLE) begin
        if (!filt_reg) begin
          gap_reg  <= '0;
          idle_reg <= 1'b0;
        end else if (gap_reg != GAP_W'(GAP_SAT)) begin
          gap_reg <= gap_reg + GAP_W'(1);
          if (gap_reg == GAP_W'(GAP_SAT - 1)) begin
            idle_reg <= 1'b1;
            if (got_byte_reg) begin
              eop_reg      <= 1'b1;
              got_byte_reg <= 1'b0;
            end
          end
        end
      end
      if (ready_reg) begin
        got_byte_reg <= 1'b1;
      end
    end
  end

  assign rx.RxD_idle        = idle_reg;
  assign rx.RxD_endofpacket = eop_reg;
`else
  assign rx.RxD_idle        = 1'b0;
  assign rx.RxD_endofpacket = 1'b0;
`endif

endmodule

// File: tb/tb_async_receiver.sv
// Self-checking bench for async_receiver: table vectors, random frames against a frame-level model,
// and hand sequences for glitch, framing error, mid-frame reset and idle detection.
module tb_async_receiver;

  localparam int     BIT     = 434;
  localparam longint LAT_MIN = 9 * BIT;
  localparam longint LAT_MAX = 4600;

  typedef struct {
    bit         err;
    logic [7:0] data;
    longint     cyc;
    logic       busy;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         gap_bits;
    bit         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  longint cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  ev_t    obs_q[$];
  ev_t    exp_q[$];
  int     obs_rd = 0;

  logic       prev_ready = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic [7:0] held       = 8'h00;
  int         hold_err   = 0;
  int         both_cnt   = 0;
  int         wide_cnt   = 0;
  int         eop_cnt    = 0;
  longint     last_eop_cyc  = 0;
  longint     last_busy_cyc = -1;

  logic [7:0] last_good = 8'h00;

  async_receiver_if rxi();

  async_receiver dut (
    .FPGA_CLK1_50 (clk),
    .reset        (reset),
    .rx           (rxi)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_ready <= rxi.RxD_data_ready;
    prev_ferr  <= rxi.RxD_frame_error;
    if (rxi.RxD_busy) last_busy_cyc <= cyc;
    if (rxi.RxD_endofpacket) begin
      eop_cnt      <= eop_cnt + 1;
      last_eop_cyc <= cyc;
    end
    if (rxi.RxD_data_ready && rxi.RxD_frame_error) both_cnt <= both_cnt + 1;
    if ((rxi.RxD_data_ready && prev_ready) || (rxi.RxD_frame_error && prev_ferr))
      wide_cnt <= wide_cnt + 1;
    if (reset) held <= 8'h00;
    else if (rxi.RxD_data_ready) held <= rxi.RxD_data;
    else if (rxi.RxD_data !== held) hold_err <= hold_err + 1;
    if (!reset && (rxi.RxD_data_ready || rxi.RxD_frame_error))
      obs_q.push_back('{rxi.RxD_frame_error, rxi.RxD_data, cyc, rxi.RxD_busy});
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: actual cycle budget exhausted, required finish before 90000 cycles");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    rxi.RxD = v;
    repeat (n * BIT) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int low_bits,
                            input int gap_bits, input bit exp_err, input logic [7:0] exp_data);
    exp_q.push_back('{exp_err, exp_data, cyc, exp_err});
    drive_bit(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 1);
    drive_bit(stop_ok, 1);
    if (!stop_ok) drive_bit(1'b0, low_bits);
    drive_bit(1'b1, gap_bits);
  endtask

  task automatic compare_events(input string tag);
    int n_obs;
    repeat (BIT / 2) @(posedge clk);
    n_obs = obs_q.size() - obs_rd;
    check({tag, " event count"}, n_obs, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
      ev_t    o;
      ev_t    e;
      longint lat;
      o   = obs_q[obs_rd + i];
      e   = exp_q[i];
      lat = o.cyc - e.cyc;
      check($sformatf("%s[%0d] frame_error", tag, i), o.err, e.err);
      check($sformatf("%s[%0d] data", tag, i), o.data, e.data);
      check($sformatf("%s[%0d] busy at strobe", tag, i), o.busy, e.busy);
      check($sformatf("%s[%0d] latency %0d in window", tag, i, lat),
            (lat >= LAT_MIN && lat <= LAT_MAX), 1);
    end
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    check({tag, " data_ready"}, rxi.RxD_data_ready, 0);
    check({tag, " data"}, rxi.RxD_data, 0);
    check({tag, " frame_error"}, rxi.RxD_frame_error, 0);
    check({tag, " busy"}, rxi.RxD_busy, 0);
    check({tag, " idle"}, rxi.RxD_idle, 0);
    check({tag, " endofpacket"}, rxi.RxD_endofpacket, 0);
  endtask

  initial begin
    vec_t       vecs[4];
    logic [7:0] b;
    bit         ok;
    longint     t0;
    longint     start41;
    int         eop_base;

    vecs[0] = '{8'h00, 1'b1, 1, 1'b0, 8'h00};
    vecs[1] = '{8'h55, 1'b1, 1, 1'b0, 8'h55};
    vecs[2] = '{8'hA5, 1'b1, 0, 1'b0, 8'hA5};
    vecs[3] = '{8'h3C, 1'b1, 1, 1'b0, 8'h3C};

    rxi.RxD = 1'b1;
    repeat (5) @(posedge clk);
    check_reset_values("por");
    @(posedge clk); #2 reset = 1'b0;
    drive_bit(1'b1, 2);

    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_ok, 0, vecs[i].gap_bits, vecs[i].exp_err, vecs[i].exp_data);
      if (!vecs[i].exp_err) last_good = vecs[i].data;
    end
    compare_events("table");

    // Framing error followed by a 3-bit break
    send_frame(8'hFF, 1'b0, 3, 0, 1'b1, last_good);
    @(negedge clk);
    check("break busy while line low", rxi.RxD_busy, 1);
    drive_bit(1'b1, 1);
    @(negedge clk);
    check("break busy after line high", rxi.RxD_busy, 0);
    compare_events("ferr");

    // 40-clock glitch must be filtered out
    t0 = cyc;
    rxi.RxD = 1'b0;
    repeat (40) @(posedge clk);
    drive_bit(1'b1, 3);
    check("glitch busy seen", (last_busy_cyc >= t0), 0);
    compare_events("glitch");

    for (int i = 0; i < 3; i++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      if (ok) begin
        send_frame(b, 1'b1, 0, $urandom_range(0, 1), 1'b0, b);
        last_good = b;
      end else begin
        send_frame(b, 1'b0, 1, 2, 1'b1, last_good);
      end
    end
    compare_events("random");

    // Reset during data bit 3 of 0x12
    b = 8'h12;
    drive_bit(1'b0, 1);
    for (int i = 0; i < 3; i++) drive_bit(b[i], 1);
    rxi.RxD = b[3];
    repeat (BIT / 2) @(posedge clk);
    @(posedge clk); #2 reset = 1'b1;
    rxi.RxD = 1'b1;
    check_reset_values("midframe reset");
    repeat (5) @(posedge clk);
    @(posedge clk); #2 reset = 1'b0;
    eop_base  = eop_cnt;
    last_good = 8'h00;
    drive_bit(1'b1, 3);
    compare_events("post reset");
    @(negedge clk);
    check("post reset data", rxi.RxD_data, 0);

    send_frame(8'h81, 1'b1, 0, 0, 1'b0, 8'h81);
    start41 = cyc;
    send_frame(8'h41, 1'b1, 0, 20, 1'b0, 8'h41);
    compare_events("idle");
    @(negedge clk);
`ifdef UART_RX_IDLE_DETECT_EN
    check("eop pulses", eop_cnt - eop_base, 1);
    check("eop timing in window",
          (last_eop_cyc - start41 >= 24 * BIT && last_eop_cyc - start41 <= 28 * BIT), 1);
    check("idle after gap", rxi.RxD_idle, 1);
`else
    check("eop pulses", eop_cnt - eop_base, 0);
    check("idle after gap", rxi.RxD_idle, 0);
`endif

    check("strobes together", both_cnt, 0);
    check("strobe wider than 1 cycle", wide_cnt, 0);
    check("data hold violations", hold_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
